// File: rtl/sprite_motion_ctrl.sv
// Sprite motion/animation controller. Buttons are synchronised, position and pose update once per frame tick.
// Latency: 2-cycle input sync, outputs registered and updated only on the screenEnd edge. No backpressure.
// SPRITE_WRAP_EN: when defined, position wraps around the playfield instead of clamping.
`timescale 1ns/1ps
module sprite_motion_ctrl #(
  parameter int X_MAX       = 160,
  parameter int Y_MAX       = 120,
  parameter int SP_W        = 8,
  parameter int SP_H        = 8,
  parameter int STEP        = 1,
  parameter int X_INIT      = 76,
  parameter int Y_INIT      = 56,
  parameter int ANIM_DIV    = 8,
  parameter int ANIM_FRAMES = 2,
  parameter int FRAME_SIZE  = 64
) (
  input  logic        clk25,
  input  logic        reset,
  input  logic        screenEnd,
  input  logic [7:0]  buttons,
  output logic        sp_en,
  output logic [31:0] sp_addr,
  output logic [7:0]  sp_x,
  output logic [6:0]  sp_y,
  output logic        moving
);

  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int PW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [8:0] X_LIM = 9'(X_MAX - SP_W);
  localparam logic [8:0] Y_LIM = 9'(Y_MAX - SP_H);
  localparam logic [8:0] STEP9 = 9'(STEP);

  typedef enum logic {IDLE, WALK} state_t;

  state_t        state_q, state_d;
  logic [4:0]    btn_s1, btn_s2;
  logic          a_prev, a_edge;
  logic          pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pose_q, pose_d;
  logic          x_neg, x_pos, y_neg, y_pos, walk;
  logic [8:0]    x_nxt, y_nxt;
  logic          en_d;
  logic [31:0]   addr_d;
  logic          unused_bits;

  // lim is the largest legal coordinate; the wrap range is lim+1
  function automatic logic [8:0] step_pos(input logic [8:0] p, input logic neg,
                                          input logic pos, input logic [8:0] lim);
    logic [8:0] r;
    r = p;
`ifdef SPRITE_WRAP_EN
    if (neg)      r = (p < STEP9) ? p + lim + 9'd1 - STEP9 : p - STEP9;
    else if (pos) r = (p + STEP9 > lim) ? p + STEP9 - lim - 9'd1 : p + STEP9;
`else
    if (neg)      r = (p < STEP9) ? 9'd0 : p - STEP9;
    else if (pos) r = (p + STEP9 > lim) ? lim : p + STEP9;
`endif
    return r;
  endfunction

  assign unused_bits = ^{buttons[7:5], x_nxt[8], y_nxt[8:7]};

  assign x_neg  = btn_s2[2] & ~btn_s2[3];
  assign x_pos  = btn_s2[3] & ~btn_s2[2];
  assign y_neg  = btn_s2[0] & ~btn_s2[1];
  assign y_pos  = btn_s2[1] & ~btn_s2[0];
  assign walk   = x_neg | x_pos | y_neg | y_pos;
  assign a_edge = btn_s2[4] & ~a_prev;
  assign moving = (state_q == WALK);

  assign x_nxt = step_pos({1'b0, sp_x}, x_neg, x_pos, X_LIM);
  assign y_nxt = step_pos({2'b00, sp_y}, y_neg, y_pos, Y_LIM);

  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (screenEnd) state_d = walk ? WALK : IDLE;
  end

  always_comb begin
    cnt_d  = cnt_q;
    pose_d = pose_q;
    pend_d = pend_q | a_edge;
    en_d   = sp_en;
    if (screenEnd) begin
      // an A edge landing on the tick itself is folded in here
      pend_d = 1'b0;
      en_d   = sp_en ^ (pend_q | a_edge);
      if (walk) begin
        if (cnt_q == CW'(ANIM_DIV - 1)) begin
          cnt_d  = '0;
          pose_d = (pose_q == PW'(ANIM_FRAMES - 1)) ? '0 : pose_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d  = '0;
        pose_d = '0;
      end
    end
    addr_d = 32'(pose_d) * 32'(FRAME_SIZE);
  end

  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      btn_s1  <= '0;
      btn_s2  <= '0;
      a_prev  <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      pose_q  <= '0;
      sp_x    <= 8'(X_INIT);
      sp_y    <= 7'(Y_INIT);
      sp_en   <= 1'b1;
      sp_addr <= '0;
    end else begin
      btn_s1 <= buttons[4:0];
      btn_s2 <= btn_s1;
      a_prev <= btn_s2[4];
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      pose_q <= pose_d;
      sp_en  <= en_d;
      if (screenEnd) begin
        sp_x    <= x_nxt[7:0];
        sp_y    <= y_nxt[6:0];
        sp_addr <= addr_d;
      end
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl with hand-computed expectations.
`timescale 1ns/1ps
module tb_sprite_motion_ctrl;
  logic        clk25 = 1'b0;
  logic        reset = 1'b1;
  logic        screenEnd = 1'b0;
  logic [7:0]  buttons = 8'h00;
  logic        sp_en;
  logic [31:0] sp_addr;
  logic [7:0]  sp_x;
  logic [6:0]  sp_y;
  logic        moving;

  int errors = 0;
  int checks = 0;

  always #20 clk25 = ~clk25;

  sprite_motion_ctrl dut (
    .clk25(clk25), .reset(reset), .screenEnd(screenEnd), .buttons(buttons),
    .sp_en(sp_en), .sp_addr(sp_addr), .sp_x(sp_x), .sp_y(sp_y), .moving(moving)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int ex, input int ey, input int en,
                           input int addr, input int mv);
    check({tag, ".x"}, 32'(sp_x), 32'(ex));
    check({tag, ".y"}, 32'(sp_y), 32'(ey));
    check({tag, ".en"}, 32'(sp_en), 32'(en));
    check({tag, ".addr"}, sp_addr, 32'(addr));
    check({tag, ".moving"}, 32'(moving), 32'(mv));
  endtask

  task automatic tick();
    @(negedge clk25);
    screenEnd = 1'b1;
    @(posedge clk25);
    #1;
    screenEnd = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick();
      repeat (2) @(posedge clk25);
      #1;
    end
  endtask

  task automatic set_btn(input logic [7:0] b);
    @(negedge clk25);
    buttons = b;
    repeat (3) @(posedge clk25);
    #1;
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int left_exp[3];
    int y_after60;
`ifdef SPRITE_WRAP_EN
    left_exp  = '{0, 152, 151};
    y_after60 = 3;
`else
    left_exp  = '{0, 0, 0};
    y_after60 = 112;
`endif
    #5 reset = 1'b0;
    #10;
    check_all("rst", 76, 56, 1, 0, 0);
    @(negedge clk25) reset = 1'b1;

    ticks(3);
    check_all("idle3", 76, 56, 1, 0, 0);

    set_btn(8'h08);
    for (int k = 1; k <= 10; k++) begin
      ticks(1);
      check($sformatf("right%0d.x", k), 32'(sp_x), 32'(76 + k));
      check($sformatf("right%0d.mv", k), 32'(moving), 32'd1);
      check($sformatf("right%0d.addr", k), sp_addr, (k >= 8) ? 32'd64 : 32'd0);
    end
    set_btn(8'h00);
    ticks(1);
    check_all("right_rel", 86, 56, 1, 0, 0);

    set_btn(8'h0F);
    for (int k = 1; k <= 4; k++) begin
      ticks(1);
      check_all($sformatf("cancel%0d", k), 86, 56, 1, 0, 0);
    end
    set_btn(8'h00);

    set_btn(8'h08);
    ticks(4);
    set_btn(8'h00);
    ticks(1);
    check_all("at90", 90, 56, 1, 0, 0);

    set_btn(8'h10);
    set_btn(8'h00);
    check("pend_hold.en", 32'(sp_en), 32'd1);
    #7 reset = 1'b0;
    #1;
    check_all("midrst", 76, 56, 1, 0, 0);
    @(posedge clk25);
    @(negedge clk25) reset = 1'b1;
    ticks(1);
    check_all("after_rst", 76, 56, 1, 0, 0);

    set_btn(8'h02);
    ticks(56);
    check_all("down56", 76, 112, 1, 64, 1);
    ticks(4);
    check_all("down60", 76, y_after60, 1, 64, 1);
    set_btn(8'h00);
    ticks(1);
    check("down_rel.mv", 32'(moving), 32'd0);

    set_btn(8'h04);
    ticks(75);
    check("left75.x", 32'(sp_x), 32'd1);
    for (int k = 0; k < 3; k++) begin
      ticks(1);
      check($sformatf("left_edge%0d.x", k), 32'(sp_x), 32'(left_exp[k]));
      check($sformatf("left_edge%0d.mv", k), 32'(moving), 32'd1);
    end
    set_btn(8'h00);
    ticks(1);

    set_btn(8'h10);
    set_btn(8'h00);
    set_btn(8'h10);
    set_btn(8'h00);
    check("dblA_pre.en", 32'(sp_en), 32'd1);
    ticks(1);
    check("dblA_tick.en", 32'(sp_en), 32'd0);
    ticks(1);
    check("dblA_next.en", 32'(sp_en), 32'd0);

    @(negedge clk25);
    buttons = 8'h10;
    @(posedge clk25);
    @(posedge clk25);
    tick();
    check("A_on_tick.en", 32'(sp_en), 32'd1);
    set_btn(8'h00);
    ticks(1);
    check("A_on_tick_next.en", 32'(sp_en), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
